uart_rx_frame_ctrl: RTL
=======================

Name: uart_rx_frame_ctrl

Overview:
Frame controller for the UART receiver, sitting directly downstream of the RX edge/bit counter.
- Drives the counter's enable.
- Consumes its edge_cnt/bit_cnt to majority-sample RX_IN mid-bit and deserialize LSB-first.
- Checks start, parity and stop bits.
- Emits one data_valid pulse per good frame, or one error pulse per bad frame.

Parameters:
DATA_WIDTH, 8, payload bits per frame (bit_cnt must reach DATA_WIDTH+2 within 4 bits)

Ports:
clk  in  1  system clock (oversampling clock, Prescale x baud)
rst_n  in  1  reset, asynchronous, active-low
RX_IN  in  1  serial line, idle high, pre-synchronized
Prescale  in  6  oversampling ratio: 8, 16 or 32; static while a frame is in flight
PAR_EN  in  1  parity bit present
PAR_TYP  in  1  0 = even, 1 = odd
edge_cnt  in  5  from counter; 0..Prescale-1 within a bit
bit_cnt  in  4  from counter; index of current bit (0 = start)
cnt_enable  out  1  to counter enable; registered
P_DATA  out  DATA_WIDTH  last good payload; held until next good frame
data_valid  out  1  one-cycle pulse, P_DATA valid same cycle
par_err  out  1  one-cycle pulse
stp_err  out  1  one-cycle pulse

Behaviour:
- Reset: state IDLE; cnt_enable=0, P_DATA=0, data_valid=0, par_err=0, stp_err=0; shift reg, sample regs and latched config cleared. Reset mid-frame aborts with no pulses.
- Sampling: capture RX_IN at edge_cnt == Prescale/2-2, Prescale/2-1 and Prescale/2.
  - Majority-of-3 = bit value.
  - "decision cycle" = edge_cnt == Prescale/2+1 (all arithmetic 6-bit, Prescale>>1).
- States:
  - IDLE:
    - cnt_enable=0.
    - RX_IN==0 -> START; cnt_enable=1 next cycle.
    - PAR_EN/PAR_TYP latched on that same cycle.
  - START:
    - At decision, bit==1 -> glitch: IDLE, cnt_enable=0 next cycle, no pulses.
    - Otherwise stay until bit_cnt==1 -> DATA.
  - DATA:
    - At each decision, shift bit in at MSB, shift right, so bit index 1 lands in P_DATA[0].
    - When bit_cnt==DATA_WIDTH+1 -> PARITY if latched PAR_EN, else STOP.
  - PARITY:
    - At decision, compare sampled bit with ^shift_reg (XOR with PAR_TYP for odd); mismatch sets internal par_fail.
    - When bit_cnt==DATA_WIDTH+2 -> STOP.
  - STOP: at decision cycle, result registered on the next edge:
    - stop==1 and !par_fail -> P_DATA<=shift reg, data_valid=1.
    - stop==0 -> stp_err=1, P_DATA unchanged.
    - par_fail -> par_err=1, P_DATA unchanged.
    - Both errors may pulse together; data_valid never coincides with an error.
    - State -> IDLE same edge; cnt_enable=0.
- Early exit: leaving after the stop-bit decision (half a bit early) lets a back-to-back start edge be detected in IDLE.
  - The counter's first-edge cycle is absorbed; timing is keyed only to edge_cnt values.
- Pulses are exactly one cycle. Flags are cleared on every non-reporting cycle.
- RX_IN activity in IDLE other than a falling level is ignored.
- Prescale values outside {8,16,32} are unsupported; no checking is performed.

Decomposition:
- Package uart_rx_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - PAR_EVEN/PAR_ODD constants;
  - sample-offset constants (-2, -1, 0, +1 relative to Prescale/2).
- One sub-module, uart_rx_data_sampler: three sample flops plus the majority vote, with a sample_en input driven by the FSM.
- Counter remains a separate instance; the RX top wires cnt_enable to it and its counts back.

Test Plan:
- Prescale=8, PAR_EN=0, frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> single data_valid, P_DATA=0xA5, no errors, cnt_enable low within 1 cycle after.
- Prescale=16, PAR_EN=1, PAR_TYP=0, 0x3C with parity bit 0 -> data_valid, P_DATA=0x3C; repeat with parity bit 1 -> par_err pulse only, P_DATA stays 0x3C.
- Prescale=32, PAR_EN=0, 0x81 with stop bit 0 -> stp_err pulse, no data_valid; next good frame 0x7E -> data_valid, P_DATA=0x7E.
- Prescale=16, RX_IN low for 3 clocks then high -> return to IDLE after decision cycle, cnt_enable drops, no pulses; a following 0x55 frame is received correctly.
- Prescale=8, frames 0x12 and 0x34 back-to-back, zero idle -> two data_valid pulses, P_DATA 0x12 then 0x34.
- Prescale=8, assert rst_n=0 during data bit 4 of 0xFF -> all outputs at reset values immediately; clean 0x0F frame afterwards -> data_valid, P_DATA=0x0F.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame controller.
// The sample and decision offsets are measured from the middle of the bit, which is Prescale/2.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int SMP_OFS_EARLY = -2;
  localparam int SMP_OFS_MID   = -1;
  localparam int SMP_OFS_LATE  = 0;
  localparam int DECIDE_OFS    = 1;

  // Wraps modulo 64 on purpose, so that negative offsets reduce correctly.
  function automatic logic [5:0] mid_offset(input logic [5:0] prescale, input int ofs);
    return (prescale >> 1) + 6'(ofs);
  endfunction

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// This interface carries the frame controller's line, config, counter and result signals.
// The slave side is the controller. The master side is the environment that drives it.
interface uart_rx_frame_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  RX_IN;
  logic [5:0]            Prescale;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [4:0]            edge_cnt;
  logic [3:0]            bit_cnt;
  logic                  cnt_enable;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;

  modport slave (
    input  RX_IN, Prescale, PAR_EN, PAR_TYP, edge_cnt, bit_cnt,
    output cnt_enable, P_DATA, data_valid, par_err, stp_err
  );

  modport master (
    output RX_IN, Prescale, PAR_EN, PAR_TYP, edge_cnt, bit_cnt,
    input  cnt_enable, P_DATA, data_valid, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx_data_sampler.sv
// Captures RX_IN at three edge counts around the middle of the bit.
// The bit value is the majority vote of those three captures.
module uart_rx_data_sampler
  import uart_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_en_i,
  input  logic       rx_i,
  input  logic [5:0] prescale_i,
  input  logic [5:0] edge_i,
  output logic       bit_o
);

  logic [2:0] smp_q;
  logic [5:0] hit_edge [3];

  assign hit_edge[0] = mid_offset(prescale_i, SMP_OFS_EARLY);
  assign hit_edge[1] = mid_offset(prescale_i, SMP_OFS_MID);
  assign hit_edge[2] = mid_offset(prescale_i, SMP_OFS_LATE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q <= '0;
    end else if (sample_en_i) begin
      for (int i = 0; i < 3; i++) begin
        if (edge_i == hit_edge[i]) smp_q[i] <= rx_i;
      end
    end
  end

  assign bit_o = majority3(smp_q);

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame FSM: it enables the bit counter, deserializes the payload LSB-first,
// and checks the start, parity and stop bits. It reports each frame with a one-cycle pulse.
module uart_rx_frame_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_rx_frame_ctrl_if.slave  bus
);

  localparam logic [3:0] BIT_AFTER_DATA = 4'(DATA_WIDTH + 1);
  localparam logic [3:0] BIT_AFTER_PAR  = 4'(DATA_WIDTH + 2);

  rx_state_e             state_q;
  logic                  cnt_enable_q;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  data_valid_q;
  logic                  par_err_q;
  logic                  stp_err_q;
  logic                  par_fail_q;
  logic                  par_en_q;
  logic                  par_typ_q;

  logic [5:0] edge_w;
  logic       decide;
  logic       sample_en;
  logic       rx_bit;
  logic       par_expect;

  assign edge_w     = {1'b0, bus.edge_cnt};
  assign decide     = (edge_w == mid_offset(bus.Prescale, DECIDE_OFS));
  assign sample_en  = (state_q != IDLE);
  assign par_expect = (^shift_q) ^ (par_typ_q == PAR_ODD);

  uart_rx_data_sampler u_sampler (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_en_i(sample_en),
    .rx_i       (bus.RX_IN),
    .prescale_i (bus.Prescale),
    .edge_i     (edge_w),
    .bit_o      (rx_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_enable_q <= 1'b0;
      p_data_q     <= '0;
      shift_q      <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      par_fail_q   <= 1'b0;
      par_en_q     <= 1'b0;
      par_typ_q    <= PAR_EVEN;
    end else begin
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_enable_q <= 1'b0;
          if (!bus.RX_IN) begin
            state_q      <= START;
            cnt_enable_q <= 1'b1;
            par_en_q     <= bus.PAR_EN;
            par_typ_q    <= bus.PAR_TYP;
            par_fail_q   <= 1'b0;
          end
        end
        START: begin
          if (decide && rx_bit) begin
            state_q      <= IDLE;
            cnt_enable_q <= 1'b0;
          end else if (bus.bit_cnt == 4'd1) begin
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bus.bit_cnt == BIT_AFTER_DATA) begin
            state_q <= par_en_q ? PARITY : STOP;
          end else if (decide) begin
            shift_q <= {rx_bit, shift_q[DATA_WIDTH-1:1]};
          end
        end
        PARITY: begin
          if (bus.bit_cnt == BIT_AFTER_PAR) begin
            state_q <= STOP;
          end else if (decide && (rx_bit != par_expect)) begin
            par_fail_q <= 1'b1;
          end
        end
        STOP: begin
          // Leave half a bit early so that a back-to-back start edge is seen in IDLE.
          if (decide) begin
            state_q      <= IDLE;
            cnt_enable_q <= 1'b0;
            stp_err_q    <= ~rx_bit;
            par_err_q    <= par_fail_q;
            if (rx_bit && !par_fail_q) begin
              p_data_q     <= shift_q;
              data_valid_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q      <= IDLE;
          cnt_enable_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cnt_enable = cnt_enable_q;
  assign bus.P_DATA     = p_data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.par_err    = par_err_q;
  assign bus.stp_err    = stp_err_q;

endmodule
